// File: rtl/fifo_read_drainer.sv
// Drains a synchronous FIFO into a 4-deep skid buffer presented as a valid/ready stream.
// Latency: read_enable in cycle N -> word on m_data with m_valid in cycle N+2 (empty buffer).
// Backpressure: m_ready low holds the head word; reads stop once buffered + in-flight words reach 4.
module fifo_read_drainer #(
  parameter int DATA_WIDTH = 9
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  rempty,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [15:0]           rd_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] buf_q [4];
  logic [15:0]           rd_count_q;

  logic [2:0] committed;
  logic       push;
  logic       pop;

  // Words already owned by this block: buffered plus the one the FIFO is returning now.
  assign committed = occ_q + {2'b00, inflight_q};

  // Reads only look at registered state and rempty, so m_ready/enable never reach read_enable.
  assign read_enable = (state_q == RUN) & ~rempty & (committed < 3'd4) & ~rrst;

  assign m_valid  = (occ_q != 3'd0) & ~rrst;
  assign m_data   = buf_q[rd_ptr_q];
  assign busy     = (state_q != IDLE) & ~rrst;
  assign rd_count = rrst ? 16'h0000 : rd_count_q;

  // The only push source is the word returned for last cycle's accepted read.
  assign push = inflight_q;
  assign pop  = m_valid & m_ready;

  // Occupancy tracks push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Mode control: RUN issues reads, DRAIN lets in-flight and buffered words flush out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = DRAIN;
      end
      DRAIN: begin
        if (enable)                                       state_d = RUN;
        else if ((occ_q == 3'd0) && (inflight_q == 1'b0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, occupancy, pointers and transfer counter; reset discards everything in flight.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= IDLE;
      occ_q      <= 3'd0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      rd_count_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= read_enable;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 2'd1;
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  // Buffer storage needs no reset; validity is carried entirely by occ_q.
  always_ff @(posedge rclk) begin
    if (push && !rrst) buf_q[wr_ptr_q] <= data_read;
  end

endmodule

// File: tb/tb_fifo_read_drainer.sv
module tb_fifo_read_drainer;

  localparam int DW     = 9;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DRN  = 2;

  logic          rclk;
  logic          rrst;
  logic          enable;
  logic          rempty;
  logic          read_enable;
  logic [DW-1:0] data_read;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [15:0]   rd_count;

  int checks = 0;
  int errors = 0;
  int re_seen = 0;

  // Reference model: external FIFO contents, words delivered to the buffer, word in flight.
  logic [DW-1:0] src  [$];
  logic [DW-1:0] outq [$];
  bit            infl;
  logic [DW-1:0] infl_word;
  int            mode;
  logic [15:0]   cnt;

  fifo_read_drainer #(.DATA_WIDTH(DW)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .enable      (enable),
    .rempty      (rempty),
    .read_enable (read_enable),
    .data_read   (data_read),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .rd_count    (rd_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) src.push_back(DW'(first + i));
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model at the edge.
  task automatic step(input bit rst, input bit en, input bit mr, input bit gap);
    bit  exp_re;
    bit  exp_v;
    int  occ_old;
    bit  infl_old;
    rrst    = rst;
    enable  = en;
    m_ready = mr;
    rempty  = (src.size() == 0) || gap;
    #1;
    exp_re = !rst && (mode == M_RUN) && !rempty && ((outq.size() + int'(infl)) < 4);
    exp_v  = !rst && (outq.size() != 0);
    chk("read_enable", 32'(read_enable), 32'(exp_re));
    chk("m_valid", 32'(m_valid), 32'(exp_v));
    if (exp_v) chk("m_data", 32'(m_data), 32'(outq[0]));
    chk("busy", 32'(busy), 32'(!rst && (mode != M_IDLE)));
    chk("rd_count", 32'(rd_count), rst ? 32'd0 : 32'(cnt));
    if (read_enable === 1'b1) re_seen++;
    @(posedge rclk);
    occ_old  = outq.size();
    infl_old = infl;
    if (rst) begin
      mode = M_IDLE;
      outq.delete();
      infl = 1'b0;
      cnt  = 16'h0000;
    end else begin
      if (exp_v && mr) begin
        void'(outq.pop_front());
        cnt = cnt + 16'd1;
      end
      if (infl_old) outq.push_back(infl_word);
      case (mode)
        M_IDLE:  if (en) mode = M_RUN;
        M_RUN:   if (!en) mode = M_DRN;
        default: begin
          if (en) mode = M_RUN;
          else if (occ_old == 0 && !infl_old) mode = M_IDLE;
        end
      endcase
      infl = exp_re;
      if (exp_re) infl_word = src.pop_front();
    end
    #1;
    data_read = infl ? infl_word : DW'($urandom);
    @(negedge rclk);
  endtask

  initial begin
    mode      = M_IDLE;
    infl      = 1'b0;
    infl_word = '0;
    cnt       = 16'h0000;
    rrst      = 1'b1;
    enable    = 1'b1;
    rempty    = 1'b0;
    m_ready   = 1'b0;
    data_read = '0;
    @(posedge rclk);
    @(negedge rclk);

    // Reset held with enable=1 and a non-empty FIFO: everything quiet.
    load(1, 8);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);

    // Straight drain of 1..8 with downstream always ready.
    for (int i = 0; i < 14; i++) step(0, 1, 1, 0);
    chk("rd_count_after_8", 32'(rd_count), 32'd8);

    // Downstream stalled: reads stop at 4, head word holds.
    step(1, 0, 0, 0);
    src.delete();
    load(1, 8);
    re_seen = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("reads_while_stalled", 32'(re_seen), 32'd4);
    chk("held_head", 32'(m_data), 32'h001);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 0);
    chk("rd_count_after_stall", 32'(rd_count), 32'd8);

    // Enable dropped right after a read: drain the 3 committed words, then idle.
    step(1, 0, 0, 0);
    src.delete();
    load(16'h20, 10);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    re_seen = 0;
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("no_reads_in_drain", 32'(re_seen), 32'd0);
    chk("drain_delivered", 32'(rd_count), 32'd3);
    chk("idle_after_drain", 32'(busy), 32'd0);

    // rempty toggling every cycle.
    step(1, 0, 0, 0);
    src.delete();
    load(16'h40, 12);
    for (int i = 0; i < 34; i++) step(0, 1, 1, 1'(i % 2));
    chk("rd_count_toggle", 32'(rd_count), 32'd12);

    // Randomized traffic with occasional reset.
    step(1, 0, 0, 0);
    src.delete();
    for (int i = 0; i < 400; i++) begin
      if (src.size() < 4) src.push_back(DW'($urandom));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end

    // Counter wrap: fill the buffer, preset the count, then two transfers.
    step(1, 0, 0, 0);
    src.delete();
    load(16'h80, 4);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    force dut.rd_count_q = 16'hFFFE;
    #1;
    release dut.rd_count_q;
    cnt = 16'hFFFE;
    step(0, 1, 1, 0);
    chk("rd_count_ffff", 32'(rd_count), 32'h0000FFFF);
    step(0, 1, 1, 0);
    chk("rd_count_wrap", 32'(rd_count), 32'h00000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
